// File: rtl/debouncer_multi.sv
// N-channel debouncer: 2-flop synchroniser, stability filter, press/release pulses
// and optional hold-to-repeat. All outputs are registered in the CLK50M domain.
module debouncer_multi #(
    parameter int N             = 2,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter int STABLE_CYCLES = 500000,
    parameter bit REPEAT_EN     = 1'b0,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic         CLK50M,
    input  logic         Reset,
    input  logic [N-1:0] A_noisy,
    output logic [N-1:0] A,
    output logic [N-1:0] Press,
    output logic [N-1:0] Release,
    output logic [N-1:0] Repeat
);
    localparam int CNT_W   = $clog2(STABLE_CYCLES);
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DLY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PER_LAST = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {RELEASED, HELD, REPEATING} state_t;

    logic [N-1:0] norm, s1, s2;

    assign norm = ACTIVE_LOW ? ~A_noisy : A_noisy;

    // NOTE: sequential state always uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge CLK50M or posedge Reset) begin
        if (Reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= norm;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t           state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic [TMR_W-1:0] tmr, tmr_nxt;
        logic             a_q, a_nxt;
        logic             press_q, press_nxt;
        logic             rel_q, rel_nxt;
        logic             rep_q, rep_nxt;
        logic             acc_press, acc_rel;

        always_ff @(posedge CLK50M or posedge Reset) begin
            if (Reset) begin
                state   <= RELEASED;
                cnt     <= '0;
                tmr     <= '0;
                a_q     <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                state   <= state_nxt;
                cnt     <= cnt_nxt;
                tmr     <= tmr_nxt;
                a_q     <= a_nxt;
                press_q <= press_nxt;
                rel_q   <= rel_nxt;
                rep_q   <= rep_nxt;
            end
        end

        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        always_comb begin
            a_nxt     = a_q;
            cnt_nxt   = cnt;
            state_nxt = state;
            tmr_nxt   = tmr;
            press_nxt = 1'b0;
            rel_nxt   = 1'b0;
            rep_nxt   = 1'b0;
            acc_press = 1'b0;
            acc_rel   = 1'b0;

            // Any sample matching the accepted level throws away the accumulated count.
            if (s2[i] == a_q) begin
                cnt_nxt = '0;
            end else if (cnt == CNT_LAST) begin
                a_nxt     = s2[i];
                cnt_nxt   = '0;
                acc_press = s2[i];
                acc_rel   = ~s2[i];
            end else begin
                cnt_nxt = cnt + 1'b1;
            end

            case (state)
                RELEASED: begin
                    if (acc_press) begin
                        state_nxt = HELD;
                        tmr_nxt   = '0;
                        press_nxt = 1'b1;
                    end
                end
                HELD: begin
                    if (acc_rel) begin
                        state_nxt = RELEASED;
                        tmr_nxt   = '0;
                        rel_nxt   = 1'b1;
                    end else if (REPEAT_EN && tmr == DLY_LAST) begin
                        state_nxt = REPEATING;
                        tmr_nxt   = '0;
                        press_nxt = 1'b1;
                        rep_nxt   = 1'b1;
                    end else if (REPEAT_EN) begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                REPEATING: begin
                    // Release takes priority over a repeat due in the same cycle.
                    if (acc_rel) begin
                        state_nxt = RELEASED;
                        tmr_nxt   = '0;
                        rel_nxt   = 1'b1;
                    end else if (tmr == PER_LAST) begin
                        tmr_nxt   = '0;
                        press_nxt = 1'b1;
                        rep_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = RELEASED;
                    tmr_nxt   = '0;
                end
            endcase
        end

        assign A[i]       = a_q;
        assign Press[i]   = press_q;
        assign Release[i] = rel_q;
        assign Repeat[i]  = rep_q;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: reset, latency, bounce rejection, repeat, concurrency,
// and an ACTIVE_LOW=0 / REPEAT_EN=0 instance.
module tb_debouncer_multi;
    logic       clk;
    logic       rst;
    logic [1:0] raw, a, press, rel, rep;
    logic [1:0] raw2, a2, press2, rel2, rep2;

    int checks = 0;
    int errors = 0;

    debouncer_multi #(
        .N(2), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(4),
        .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut (
        .CLK50M(clk), .Reset(rst), .A_noisy(raw),
        .A(a), .Press(press), .Release(rel), .Repeat(rep)
    );

    debouncer_multi #(
        .N(2), .ACTIVE_LOW(1'b0), .STABLE_CYCLES(4),
        .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) dut2 (
        .CLK50M(clk), .Reset(rst), .A_noisy(raw2),
        .A(a2), .Press(press2), .Release(rel2), .Repeat(rep2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [1:0] ea, input logic [1:0] ep,
                        input logic [1:0] er, input logic [1:0] erp);
        check({tag, "_A"}, 32'(a), 32'(ea));
        check({tag, "_Press"}, 32'(press), 32'(ep));
        check({tag, "_Release"}, 32'(rel), 32'(er));
        check({tag, "_Repeat"}, 32'(rep), 32'(erp));
    endtask

    // Advance n rising edges; sampling happens 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pc;
        int  rc;
        bit  found;
        logic r0;

        // 1. Reset with both channels held pressed, then release reset.
        rst  = 1'b0;
        raw  = 2'b00;
        raw2 = 2'b00;
        #1 rst = 1'b1;
        tick(3);
        chk4("s1_reset", 2'b00, 2'b00, 2'b00, 2'b00);
        check("s1_reset_A2", 32'(a2), 32'd0);
        rst = 1'b0;
        tick(5);
        chk4("s1_pre_accept", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s1_accept", 2'b11, 2'b11, 2'b00, 2'b00);
        tick(1);
        chk4("s1_pulse_end", 2'b11, 2'b00, 2'b00, 2'b00);
        raw = 2'b11;
        tick(5);
        chk4("s1_pre_release", 2'b11, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s1_release", 2'b00, 2'b00, 2'b11, 2'b00);
        tick(1);
        chk4("s1_release_end", 2'b00, 2'b00, 2'b00, 2'b00);

        // 2. Clean press and release on ch0.
        raw = 2'b10;
        tick(5);
        chk4("s2_pre_press", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s2_press", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        chk4("s2_press_end", 2'b01, 2'b00, 2'b00, 2'b00);
        raw = 2'b11;
        tick(5);
        chk4("s2_pre_release", 2'b01, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s2_release", 2'b00, 2'b00, 2'b01, 2'b00);
        tick(1);
        chk4("s2_release_end", 2'b00, 2'b00, 2'b00, 2'b00);

        // 3. Bounce on ch0 every 3 cycles must never be accepted.
        for (int i = 0; i < 40; i++) begin
            r0  = (((i / 3) % 2) == 0) ? 1'b0 : 1'b1;
            raw = {1'b1, r0};
            tick(1);
            check("s3_bounce_A", 32'(a), 32'd0);
            check("s3_bounce_Press", 32'(press), 32'd0);
            check("s3_bounce_Release", 32'(rel), 32'd0);
        end
        raw   = 2'b10;
        found = 1'b0;
        for (int j = 0; j < 12 && !found; j++) begin
            tick(1);
            if (a[0]) found = 1'b1;
        end
        check("s3_accept_seen", 32'(found), 32'd1);
        chk4("s3_press", 2'b01, 2'b01, 2'b00, 2'b00);
        tick(1);
        chk4("s3_press_end", 2'b01, 2'b00, 2'b00, 2'b00);
        raw = 2'b11;
        tick(6);
        chk4("s3_release", 2'b00, 2'b00, 2'b01, 2'b00);
        tick(1);

        // 4. Hold ch1: press at t0, repeats at t0+10, +13, +16, +19; release wins at t0+22.
        raw = 2'b01;
        tick(6);
        chk4("s4_t0", 2'b10, 2'b10, 2'b00, 2'b00);
        tick(9);
        chk4("s4_t9", 2'b10, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s4_t10", 2'b10, 2'b10, 2'b00, 2'b10);
        tick(1);
        chk4("s4_t11", 2'b10, 2'b00, 2'b00, 2'b00);
        tick(2);
        chk4("s4_t13", 2'b10, 2'b10, 2'b00, 2'b10);
        tick(3);
        chk4("s4_t16", 2'b10, 2'b10, 2'b00, 2'b10);
        raw = 2'b11;
        tick(3);
        chk4("s4_t19", 2'b10, 2'b10, 2'b00, 2'b10);
        tick(3);
        chk4("s4_t22_release", 2'b00, 2'b00, 2'b10, 2'b00);
        for (int j = 0; j < 6; j++) begin
            tick(1);
            chk4("s4_after", 2'b00, 2'b00, 2'b00, 2'b00);
        end

        // 5. Simultaneous press, then asynchronous reset during the hold.
        raw = 2'b00;
        tick(6);
        chk4("s5_both", 2'b11, 2'b11, 2'b00, 2'b00);
        tick(2);
        rst = 1'b1;
        #2;
        chk4("s5_async_reset", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(2);
        chk4("s5_in_reset", 2'b00, 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(5);
        chk4("s5_pre_reaccept", 2'b00, 2'b00, 2'b00, 2'b00);
        tick(1);
        chk4("s5_reaccept", 2'b11, 2'b11, 2'b00, 2'b00);
        raw = 2'b11;
        tick(6);
        chk4("s5_release", 2'b00, 2'b00, 2'b11, 2'b00);

        // 6. Active-high instance without repeat: a single press over 30 held cycles.
        raw2 = 2'b01;
        pc   = 0;
        rc   = 0;
        for (int j = 1; j <= 30; j++) begin
            tick(1);
            if (press2 != 2'b00) pc++;
            if (rep2 != 2'b00) rc++;
            if (j == 5) check("s6_pre_accept_A2", 32'(a2), 32'd0);
            if (j == 6) check("s6_accept_Press2", 32'(press2), 32'd1);
        end
        check("s6_press_count", 32'(pc), 32'd1);
        check("s6_repeat_count", 32'(rc), 32'd0);
        check("s6_final_A2", 32'(a2), 32'd1);
        check("s6_release2", 32'(rel2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
